// File: rtl/alu_pkg.sv
// Opcode map, flag positions and opcode-class helpers shared by the
// issue/writeback block and its status register.
package alu_pkg;

    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_ADC   = 6'b000001;
    localparam logic [5:0] OP_SUB   = 6'b000010;
    localparam logic [5:0] OP_SBC   = 6'b000011;
    localparam logic [5:0] OP_INC   = 6'b000100;
    localparam logic [5:0] OP_DEC   = 6'b000101;
    localparam logic [5:0] OP_NEG   = 6'b000110;
    localparam logic [5:0] OP_AND   = 6'b001000;
    localparam logic [5:0] OP_OR    = 6'b001001;
    localparam logic [5:0] OP_XOR   = 6'b001010;
    localparam logic [5:0] OP_NOT   = 6'b001011;
    localparam logic [5:0] OP_SHL   = 6'b001100;
    localparam logic [5:0] OP_SHR   = 6'b001101;
    localparam logic [5:0] OP_SAR   = 6'b001110;
    localparam logic [5:0] OP_ROL   = 6'b001111;
    localparam logic [5:0] OP_ROR   = 6'b010000;
    localparam logic [5:0] OP_CMP   = 6'b010001;
    localparam logic [5:0] OP_SLT   = 6'b010010;
    localparam logic [5:0] OP_SLTU  = 6'b010011;
    localparam logic [5:0] OP_PASSA = 6'b010100;
    localparam logic [5:0] OP_PASSB = 6'b010101;
    localparam logic [5:0] OP_NOP   = 6'b111111;

    localparam int FLAG_Z = 3;
    localparam int FLAG_S = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef struct packed {
        logic [31:0] result;
        logic [3:0]  flags;
        logic        illegal;
    } wb_data_t;

    function automatic logic writes_cv(input logic [5:0] op);
        return (op <= OP_NEG) || (op == OP_CMP);
    endfunction

    function automatic logic writes_zs(input logic [5:0] op);
        return writes_cv(op) || ((op >= OP_AND) && (op <= OP_PASSB));
    endfunction

    function automatic logic is_legal(input logic [5:0] op);
        return writes_zs(op) || (op == OP_NOP);
    endfunction

endpackage

// File: rtl/alu_issue_wb_if.sv
// Op request, result, status and ALU-facing signals of alu_issue_wb.
// slave = the pipeline block, master = caller plus the external ALU.
interface alu_issue_wb_if #(parameter int TAG_W = 4);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_a;
    logic [31:0]      in_b;
    logic [5:0]       in_opcode;
    logic [TAG_W-1:0] in_tag;
    logic             flag_clr;
    logic [31:0]      alu_a;
    logic [31:0]      alu_b;
    logic [5:0]       alu_opcode;
    logic             alu_carry_in;
    logic [31:0]      alu_result;
    logic             alu_zero;
    logic             alu_sign;
    logic             alu_carry;
    logic             alu_ovf;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_result;
    logic [3:0]       out_flags;
    logic [TAG_W-1:0] out_tag;
    logic             out_illegal;
    logic [3:0]       status;

    modport slave (
        input  in_valid, in_a, in_b, in_opcode, in_tag, flag_clr, out_ready,
               alu_result, alu_zero, alu_sign, alu_carry, alu_ovf,
        output in_ready, out_valid, out_result, out_flags, out_tag, out_illegal,
               status, alu_a, alu_b, alu_opcode, alu_carry_in
    );

    modport master (
        output in_valid, in_a, in_b, in_opcode, in_tag, flag_clr, out_ready,
               alu_result, alu_zero, alu_sign, alu_carry, alu_ovf,
        input  in_ready, out_valid, out_result, out_flags, out_tag, out_illegal,
               status, alu_a, alu_b, alu_opcode, alu_carry_in
    );
endinterface

// File: rtl/alu_status_reg.sv
// Architectural {Z,S,C,V} register: per-opcode-class write masks, clear wins.
module alu_status_reg
    import alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       upd_i,
    input  logic [5:0] op_i,
    input  logic [3:0] flags_i,
    input  logic       clr_i,
    output logic [3:0] status_o
);
    logic [3:0] status_q, status_d;

    always_comb begin
        status_d = status_q;
        if (upd_i && writes_zs(op_i)) begin
            status_d[FLAG_Z] = flags_i[FLAG_Z];
            status_d[FLAG_S] = flags_i[FLAG_S];
        end
        if (upd_i && writes_cv(op_i)) begin
            status_d[FLAG_C] = flags_i[FLAG_C];
            status_d[FLAG_V] = flags_i[FLAG_V];
        end
        if (clr_i) status_d = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) status_q <= '0;
        else     status_q <= status_d;
    end

    assign status_o = status_q;
endmodule

// File: rtl/alu_issue_wb.sv
// Two-stage issue/writeback wrapper around an external combinational ALU;
// status C feeds CarryIn so carry chains issue back-to-back.
module alu_issue_wb
    import alu_pkg::*;
#(
    parameter int TAG_W = 4
) (
    input  logic          clk,
    input  logic          rst,
    alu_issue_wb_if.slave bus_io
);
    logic             iss_valid_q, iss_valid_d;
    logic [31:0]      iss_a_q, iss_a_d, iss_b_q, iss_b_d;
    logic [5:0]       iss_op_q, iss_op_d;
    logic [TAG_W-1:0] iss_tag_q, iss_tag_d;
    logic             out_valid_q, out_valid_d;
    wb_data_t         wb_q, wb_d;
    logic [TAG_W-1:0] wb_tag_q, wb_tag_d;
    logic             iss_fire, in_ready, accept, iss_illegal;
    logic [3:0]       alu_flags, status;

    assign alu_flags   = {bus_io.alu_zero, bus_io.alu_sign, bus_io.alu_carry, bus_io.alu_ovf};
    assign iss_illegal = !is_legal(iss_op_q);
    assign iss_fire    = iss_valid_q && (!out_valid_q || bus_io.out_ready);
    assign in_ready    = !iss_valid_q || iss_fire;
    assign accept      = bus_io.in_valid && in_ready;

    always_comb begin
        iss_valid_d = iss_valid_q;
        iss_a_d     = iss_a_q;
        iss_b_d     = iss_b_q;
        iss_op_d    = iss_op_q;
        iss_tag_d   = iss_tag_q;
        if (accept) begin
            iss_valid_d = 1'b1;
            iss_a_d     = bus_io.in_a;
            iss_b_d     = bus_io.in_b;
            iss_op_d    = bus_io.in_opcode;
            iss_tag_d   = bus_io.in_tag;
        end else if (iss_fire) begin
            iss_valid_d = 1'b0;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        wb_d        = wb_q;
        wb_tag_d    = wb_tag_q;
        if (iss_fire) begin
            out_valid_d = 1'b1;
            wb_d.result = iss_illegal ? 32'd0 : bus_io.alu_result;
            wb_d.flags  = alu_flags;
            wb_d.illegal = iss_illegal;
            wb_tag_d    = iss_tag_q;
        end else if (bus_io.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iss_valid_q <= 1'b0;
            iss_a_q     <= '0;
            iss_b_q     <= '0;
            iss_op_q    <= OP_NOP;
            iss_tag_q   <= '0;
            out_valid_q <= 1'b0;
            wb_q        <= '0;
            wb_tag_q    <= '0;
        end else begin
            iss_valid_q <= iss_valid_d;
            iss_a_q     <= iss_a_d;
            iss_b_q     <= iss_b_d;
            iss_op_q    <= iss_op_d;
            iss_tag_q   <= iss_tag_d;
            out_valid_q <= out_valid_d;
            wb_q        <= wb_d;
            wb_tag_q    <= wb_tag_d;
        end
    end

    // Illegal ops fire through writeback but must leave status untouched;
    // the class helpers already exclude them from both write masks.
    alu_status_reg u_status (
        .clk     (clk),
        .rst     (rst),
        .upd_i   (iss_fire),
        .op_i    (iss_op_q),
        .flags_i (alu_flags),
        .clr_i   (bus_io.flag_clr),
        .status_o(status)
    );

    assign bus_io.in_ready     = in_ready;
    assign bus_io.alu_a        = iss_a_q;
    assign bus_io.alu_b        = iss_b_q;
    assign bus_io.alu_opcode   = iss_valid_q ? iss_op_q : OP_NOP;
    assign bus_io.alu_carry_in = status[FLAG_C];
    assign bus_io.out_valid    = out_valid_q;
    assign bus_io.out_result   = wb_q.result;
    assign bus_io.out_flags    = wb_q.flags;
    assign bus_io.out_illegal  = wb_q.illegal;
    assign bus_io.out_tag      = wb_tag_q;
    assign bus_io.status       = status;
endmodule
